mem_bus_arbiter: RTL and testbench

- Shares the single 8-bit external memory bus (addrBus / dBusIn / dBusOut / rWMem) between two masters: the CPU Control unit (port 0) and the display refresh engine (port 1).
- Serialises single-byte accesses with a req/ack handshake, a round-robin tie-break and a configurable memory wait count.
- Sits between Control/video and the memory model.

---
 rtl/chipz8_bus_pkg.sv | 18 +
 rtl/mem_bus_arbiter_if.sv | 50 +++++
 rtl/rr_pick2.sv | 21 ++
 rtl/mem_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chipz8_bus_pkg.sv
// Shared types and constants for the chipz8 memory bus arbiter.
package chipz8_bus_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_VID = 1'b1;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester handshakes (CPU port 0, video port 1) plus the shared external memory bus.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              vid_req;
  logic              vid_we;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_wdata;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_ack;

  logic              busy;
  logic              gnt_id;

  logic [ADDR_W-1:0] addrBus;
  logic [DATA_W-1:0] dBusIn;
  logic [DATA_W-1:0] dBusOut;
  logic              rWMem;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  vid_req, vid_we, vid_addr, vid_wdata,
    output vid_rdata, vid_ack,
    output busy, gnt_id,
    output addrBus, dBusOut, rWMem,
    input  dBusIn
  );

  // Requesters and memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output vid_req, vid_we, vid_addr, vid_wdata,
    input  vid_rdata, vid_ack,
    input  busy, gnt_id,
    input  addrBus, dBusOut, rWMem,
    output dBusIn
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the port that did not win last time goes.
module rr_pick2
  import chipz8_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = PORT_CPU;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = PORT_VID;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises single-byte CPU/video accesses onto the shared external memory bus.
module mem_bus_arbiter
  import chipz8_bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_WAIT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic              rw_q, rw_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
  logic [1:0]        ack_q, ack_d;

  logic              pick_valid_c;
  logic              pick_port_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;

  rr_pick2 u_pick (
    .req    ({bus.vid_req, bus.cpu_req}),
    .last   (last_q),
    .valid  (pick_valid_c),
    .winner (pick_port_c)
  );

  // Request fields of whichever port the picker chose
  assign sel_we_c    = (pick_port_c == PORT_VID) ? bus.vid_we    : bus.cpu_we;
  assign sel_addr_c  = (pick_port_c == PORT_VID) ? bus.vid_addr  : bus.cpu_addr;
  assign sel_wdata_c = (pick_port_c == PORT_VID) ? bus.vid_wdata : bus.cpu_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= PORT_VID;
      gnt_q       <= PORT_CPU;
      we_q        <= RW_READ;
      rw_q        <= RW_READ;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      ack_q       <= ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    rw_d        = rw_q;
    busy_d      = busy_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    ack_d       = ack_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_c) begin
          state_d = ST_ACCESS;
          cnt_d   = WAIT_INIT;
          last_d  = pick_port_c;
          gnt_d   = pick_port_c;
          we_d    = sel_we_c;
          rw_d    = sel_we_c;
          busy_d  = 1'b1;
          addr_d  = sel_addr_c;
          dout_d  = (sel_we_c == RW_WRITE) ? sel_wdata_c : '0;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Wait count exhausted: sample read data and acknowledge the owner
          state_d      = ST_ACK;
          rw_d         = RW_READ;
          dout_d       = '0;
          ack_d[gnt_q] = 1'b1;
          if (we_q == RW_READ) begin
            if (gnt_q == PORT_VID) vid_rdata_d = bus.dBusIn;
            else                   cpu_rdata_d = bus.dBusIn;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        ack_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.vid_rdata = vid_rdata_q;
  assign bus.cpu_ack   = ack_q[PORT_CPU];
  assign bus.vid_ack   = ack_q[PORT_VID];
  assign bus.busy      = busy_q;
  assign bus.gnt_id    = gnt_q;
  assign bus.addrBus   = addr_q;
  assign bus.dBusOut   = dout_q;
  assign bus.rWMem     = rw_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  // One outstanding access, tracked by its age in cycles since the grant edge
  typedef struct {
    bit          active;
    int          age;
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    bit          last_gnt;
    bit          gnt;
    logic [7:0]  rd0;
    logic [7:0]  rd1;
  } model_t;

  typedef struct packed {
    logic [15:0] addr_bus;
    logic [7:0]  dout;
    logic        rw;
    logic        busy;
    logic        gnt;
    logic        ack0;
    logic        ack1;
    logic [7:0]  rd0;
    logic [7:0]  rd1;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;

  int   cpu_ack_n = 0;
  int   vid_ack_n = 0;
  int   wr_cyc = 0;
  int   drv_cyc = 0;
  int   mcyc = 0;
  int   ack_port[$];
  int   ack_gnt[$];
  int   ack_cyc[$];

  model_t m1, m0;
  obs_t   act1, act0;

  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_WAIT(1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (b1.slave)
  );
  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_WAIT(0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (b0.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    case (a)
      16'h0200: mem_val = 8'h03;
      16'h0201: mem_val = 8'h3C;
      16'h0300: mem_val = 8'hA7;
      default:  mem_val = a[15:8] ^ a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always_comb b1.dBusIn = mem_val(b1.addrBus);
  always_comb b0.dBusIn = mem_val(b0.addrBus);

  function automatic model_t model_reset();
    model_t r;
    r.active = 1'b0; r.age = 0; r.port = 1'b0; r.we = 1'b0;
    r.addr = 16'h0; r.wdata = 8'h0; r.last_gnt = 1'b1; r.gnt = 1'b0;
    r.rd0 = 8'h0; r.rd1 = 8'h0;
    return r;
  endfunction

  function automatic model_t step(input model_t m, input bit [1:0] req, input bit [1:0] we,
                                  input logic [15:0] a0, input logic [15:0] a1,
                                  input logic [7:0] w0, input logic [7:0] w1, input int mw);
    model_t n;
    bit win;
    n = m;
    if (m.active) begin
      n.age = m.age + 1;
      if (n.age == mw + 1 && !m.we) begin
        if (m.port) n.rd1 = mem_val(m.addr);
        else        n.rd0 = mem_val(m.addr);
      end
      if (n.age == mw + 2) n.active = 1'b0;
    end else if (req != 2'b00) begin
      win = (req == 2'b11) ? !m.last_gnt : req[1];
      n.active = 1'b1; n.age = 0; n.port = win; n.we = we[win];
      n.addr = win ? a1 : a0; n.wdata = win ? w1 : w0;
      n.last_gnt = win; n.gnt = win;
    end
    return n;
  endfunction

  function automatic obs_t expect_of(input model_t m, input int mw);
    obs_t o;
    bit drv, ackp;
    drv  = m.active && (m.age <= mw);
    ackp = m.active && (m.age == mw + 1);
    o.addr_bus = m.addr;
    o.rw       = drv && m.we;
    o.dout     = (drv && m.we) ? m.wdata : 8'h00;
    o.busy     = m.active;
    o.gnt      = m.gnt;
    o.ack0     = ackp && !m.port;
    o.ack1     = ackp && m.port;
    o.rd0      = m.rd0;
    o.rd1      = m.rd1;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".addrBus"}, 32'(a.addr_bus), 32'(e.addr_bus));
    chk({tag, ".dBusOut"}, 32'(a.dout), 32'(e.dout));
    chk({tag, ".rWMem"}, 32'(a.rw), 32'(e.rw));
    chk({tag, ".busy"}, 32'(a.busy), 32'(e.busy));
    chk({tag, ".gnt_id"}, 32'(a.gnt), 32'(e.gnt));
    chk({tag, ".cpu_ack"}, 32'(a.ack0), 32'(e.ack0));
    chk({tag, ".vid_ack"}, 32'(a.ack1), 32'(e.ack1));
    chk({tag, ".cpu_rdata"}, 32'(a.rd0), 32'(e.rd0));
    chk({tag, ".vid_rdata"}, 32'(a.rd1), 32'(e.rd1));
  endtask

  // Model advances on the same edges as the DUT, including the async reset
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m1 = model_reset();
      m0 = model_reset();
    end else begin
      m1 = step(m1, {b1.vid_req, b1.cpu_req}, {b1.vid_we, b1.cpu_we}, b1.cpu_addr, b1.vid_addr,
                b1.cpu_wdata, b1.vid_wdata, 1);
      m0 = step(m0, {b0.vid_req, b0.cpu_req}, {b0.vid_we, b0.cpu_we}, b0.cpu_addr, b0.vid_addr,
                b0.cpu_wdata, b0.vid_wdata, 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      act1 = {b1.addrBus, b1.dBusOut, b1.rWMem, b1.busy, b1.gnt_id, b1.cpu_ack, b1.vid_ack,
              b1.cpu_rdata, b1.vid_rdata};
      act0 = {b0.addrBus, b0.dBusOut, b0.rWMem, b0.busy, b0.gnt_id, b0.cpu_ack, b0.vid_ack,
              b0.cpu_rdata, b0.vid_rdata};
      cmp("w1", act1, expect_of(m1, 1));
      cmp("w0", act0, expect_of(m0, 0));
    end
  end

  always @(negedge clk) begin
    mcyc++;
    if (b1.cpu_ack === 1'b1) cpu_ack_n++;
    if (b1.vid_ack === 1'b1) vid_ack_n++;
    if (b1.rWMem === 1'b1) wr_cyc++;
    if (b1.busy === 1'b1 && b1.cpu_ack !== 1'b1 && b1.vid_ack !== 1'b1) drv_cyc++;
    if (b1.cpu_ack === 1'b1 || b1.vid_ack === 1'b1) begin
      ack_port.push_back((b1.vid_ack === 1'b1) ? 1 : 0);
      ack_gnt.push_back(int'(b1.gnt_id));
      ack_cyc.push_back(mcyc);
    end
  end

  task automatic clr();
    cpu_ack_n = 0; vid_ack_n = 0; wr_cyc = 0; drv_cyc = 0;
    ack_port.delete(); ack_gnt.delete(); ack_cyc.delete();
  endtask

  task automatic wait_ack1(input bit port, output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if ((port ? b1.vid_ack : b1.cpu_ack) === 1'b1) return;
    end
    chk("ack_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_acks(input int n);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      if (ack_port.size() >= n) return;
    end
    chk("ack_count_timeout", 32'(ack_port.size()), 32'(n));
  endtask

  initial begin
    int lat;
    int lat2;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.vid_req = 0; b1.vid_we = 0; b1.vid_addr = '0; b1.vid_wdata = '0;
    b0.cpu_req = 0; b0.cpu_we = 0; b0.cpu_addr = '0; b0.cpu_wdata = '0;
    b0.vid_req = 0; b0.vid_we = 0; b0.vid_addr = '0; b0.vid_wdata = '0;
    #1 rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.addrBus", 32'(b1.addrBus), 32'h0);
    chk("rst.busy", 32'(b1.busy), 32'h0);
    chk("rst.gnt_id", 32'(b1.gnt_id), 32'h0);
    chk("rst.rWMem", 32'(b1.rWMem), 32'h0);
    chk("rst.acks", 32'({b1.cpu_ack, b1.vid_ack}), 32'h0);
    chk("rst.rdata", 32'({b1.cpu_rdata, b1.vid_rdata}), 32'h0);
    rst = 1'b1;

    // CPU read of 0x0200
    @(negedge clk); #1;
    clr();
    b1.cpu_we = 0; b1.cpu_addr = 16'h0200; b1.cpu_req = 1;
    wait_ack1(1'b0, lat);
    #1 b1.cpu_req = 0;
    chk("t1.latency", 32'(lat), 32'd3);
    chk("t1.cpu_rdata", 32'(b1.cpu_rdata), 32'h03);
    repeat (3) @(negedge clk);
    #1;
    chk("t1.cpu_acks", 32'(cpu_ack_n), 32'd1);
    chk("t1.vid_acks", 32'(vid_ack_n), 32'd0);
    chk("t1.drive_cycles", 32'(drv_cyc), 32'd2);
    chk("t1.write_cycles", 32'(wr_cyc), 32'd0);

    // Video write of 0x55 to 0x0F00
    clr();
    b1.vid_we = 1; b1.vid_addr = 16'h0F00; b1.vid_wdata = 8'h55; b1.vid_req = 1;
    wait_ack1(1'b1, lat);
    #1 b1.vid_req = 0;
    chk("t2.latency", 32'(lat), 32'd3);
    chk("t2.vid_rdata", 32'(b1.vid_rdata), 32'h00);
    repeat (3) @(negedge clk);
    #1;
    chk("t2.write_cycles", 32'(wr_cyc), 32'd2);
    chk("t2.vid_acks", 32'(vid_ack_n), 32'd1);
    chk("t2.cpu_acks", 32'(cpu_ack_n), 32'd0);
    chk("t2.cpu_rdata", 32'(b1.cpu_rdata), 32'h03);

    // Fresh reset, then both ports request together and hold
    rst = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    clr();
    b1.cpu_we = 0; b1.cpu_addr = 16'h0200;
    b1.vid_we = 0; b1.vid_addr = 16'h0F00;
    b1.cpu_req = 1; b1.vid_req = 1;
    wait_acks(4);
    b1.cpu_req = 0; b1.vid_req = 0;
    if (ack_port.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t3.ack_port", 32'(ack_port[i]), 32'(i % 2));
        chk("t3.gnt_id", 32'(ack_gnt[i]), 32'(i % 2));
      end
      for (int i = 0; i < 3; i++) chk("t3.ack_gap", 32'(ack_cyc[i+1] - ack_cyc[i]), 32'd4);
    end
    repeat (3) @(negedge clk);
    #1;

    // CPU back-to-back reads, req held through the first ack
    clr();
    b1.cpu_we = 0; b1.cpu_addr = 16'h0200; b1.cpu_req = 1;
    wait_ack1(1'b0, lat);
    #1 b1.cpu_addr = 16'h0201;
    chk("t4.rdata_first", 32'(b1.cpu_rdata), 32'h03);
    wait_ack1(1'b0, lat2);
    #1 b1.cpu_req = 0;
    chk("t4.ack_gap", 32'(lat2), 32'd4);
    chk("t4.rdata_second", 32'(b1.cpu_rdata), 32'h3C);
    repeat (3) @(negedge clk);
    #1;
    chk("t4.write_cycles", 32'(wr_cyc), 32'd0);
    chk("t4.cpu_acks", 32'(cpu_ack_n), 32'd2);

    // Asynchronous reset in the middle of an access
    clr();
    b1.cpu_we = 0; b1.cpu_addr = 16'h0300; b1.cpu_req = 1;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5.addrBus", 32'(b1.addrBus), 32'h0);
    chk("t5.busy", 32'(b1.busy), 32'h0);
    chk("t5.rWMem", 32'(b1.rWMem), 32'h0);
    chk("t5.cpu_rdata", 32'(b1.cpu_rdata), 32'h0);
    chk("t5.vid_rdata", 32'(b1.vid_rdata), 32'h0);
    chk("t5.gnt_id", 32'(b1.gnt_id), 32'h0);
    b1.cpu_req = 0;
    @(negedge clk); #1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("t5.no_ack", 32'(cpu_ack_n), 32'd0);
    clr();
    b1.cpu_addr = 16'h0200; b1.vid_addr = 16'h0F00; b1.vid_we = 0;
    b1.cpu_req = 1; b1.vid_req = 1;
    wait_acks(1);
    b1.cpu_req = 0; b1.vid_req = 0;
    if (ack_port.size() >= 1) chk("t5.first_tie", 32'(ack_port[0]), 32'd0);
    repeat (3) @(negedge clk);
    #1;

    // Zero-wait instance: CPU read of 0x0300
    b0.cpu_we = 0; b0.cpu_addr = 16'h0300; b0.cpu_req = 1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (b0.cpu_ack === 1'b1) break;
    end
    #1 b0.cpu_req = 0;
    chk("t6.latency", 32'(lat), 32'd2);
    chk("t6.cpu_rdata", 32'(b0.cpu_rdata), 32'hA7);
    @(negedge clk);
    #1;
    chk("t6.idle_third_cycle", 32'(b0.busy), 32'h0);
    chk("t6.ack_dropped", 32'(b0.cpu_ack), 32'h0);
    repeat (2) @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
